// File: rtl/eth_tx_framer.sv
// Ethernet transmit framer. It zero-pads frames to MIN_LEN, drops input bytes beyond MAX_LEN,
// and appends the IEEE 802.3 FCS. All output bytes pass through a single output register.
module eth_tx_framer #(
  parameter int unsigned MIN_LEN = 60,
  parameter int unsigned MAX_LEN = 1514
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  in_data,
  input  logic        in_valid,
  input  logic        in_last,
  output logic        in_ready,
  output logic [7:0]  out_data,
  output logic        out_valid,
  output logic        out_last,
  input  logic        out_ready,
  output logic        frame_done,
  output logic [10:0] frame_len,
  output logic        frame_err
);

  localparam int unsigned CNT_W    = 11;
  localparam logic [31:0] CRC_POLY = 32'hEDB88320;
  localparam logic [31:0] CRC_INIT = 32'hFFFFFFFF;

  typedef enum logic [1:0] {S_IDLE, S_DATA, S_PAD, S_FCS} state_t;

  state_t             r_state, w_state_nxt;
  logic [7:0]         r_data, w_data_nxt;
  logic               r_valid, w_valid_nxt;
  logic               r_last, w_last_nxt;
  logic [CNT_W-1:0]   r_cnt, w_cnt_nxt;
  logic               r_ovf, w_ovf_nxt;
  logic [31:0]        r_crc, w_crc_nxt;
  logic [2:0]         r_idx, w_idx_nxt;
  logic               r_done, w_done_nxt;
  logic [CNT_W-1:0]   r_len, w_len_nxt;
  logic               r_err, w_err_nxt;

  logic               w_adv;
  logic               w_in_ok;
  logic               w_acc;
  logic [CNT_W-1:0]   w_cnt_inc;
  logic [7:0]         w_fcs_byte;

  // Reflected CRC-32 update over one byte, LSB first
  function automatic logic [31:0] crc_byte(input logic [31:0] c, input logic [7:0] d);
    logic [31:0] x;
    x = c ^ {24'd0, d};
    for (int i = 0; i < 8; i++) begin
      x = x[0] ? ((x >> 1) ^ CRC_POLY) : (x >> 1);
    end
    return x;
  endfunction

  assign w_adv      = ~r_valid | out_ready;
  assign w_in_ok    = ((r_state == S_IDLE) || (r_state == S_DATA)) && w_adv;
  assign w_acc      = in_valid & w_in_ok;
  assign w_cnt_inc  = r_cnt + CNT_W'(1);
  assign w_fcs_byte = ~r_crc[{r_idx[1:0], 3'b000} +: 8];

  assign in_ready   = w_in_ok & ~rst;
  assign out_data   = r_data;
  assign out_valid  = r_valid;
  assign out_last   = r_last;
  assign frame_done = r_done;
  assign frame_len  = r_len;
  assign frame_err  = r_err;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_data  <= 8'h00;
      r_valid <= 1'b0;
      r_last  <= 1'b0;
      r_cnt   <= '0;
      r_ovf   <= 1'b0;
      r_crc   <= CRC_INIT;
      r_idx   <= 3'd0;
      r_done  <= 1'b0;
      r_len   <= '0;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_data  <= w_data_nxt;
      r_valid <= w_valid_nxt;
      r_last  <= w_last_nxt;
      r_cnt   <= w_cnt_nxt;
      r_ovf   <= w_ovf_nxt;
      r_crc   <= w_crc_nxt;
      r_idx   <= w_idx_nxt;
      r_done  <= w_done_nxt;
      r_len   <= w_len_nxt;
      r_err   <= w_err_nxt;
    end
  end

  // Next state and output-stage loading
  always_comb begin
    w_state_nxt = r_state;
    w_data_nxt  = r_data;
    w_valid_nxt = r_valid & ~out_ready;
    w_last_nxt  = r_last;
    w_cnt_nxt   = r_cnt;
    w_ovf_nxt   = r_ovf;
    w_crc_nxt   = r_crc;
    w_idx_nxt   = r_idx;
    w_done_nxt  = 1'b0;
    w_len_nxt   = r_len;
    w_err_nxt   = r_err;

    unique case (r_state)
      S_IDLE, S_DATA: begin
        if (w_acc) begin
          w_state_nxt = S_DATA;
          if (r_cnt < CNT_W'(MAX_LEN)) begin
            w_data_nxt  = in_data;
            w_valid_nxt = 1'b1;
            w_last_nxt  = 1'b0;
            w_crc_nxt   = crc_byte(r_crc, in_data);
            w_cnt_nxt   = w_cnt_inc;
          end else begin
            w_ovf_nxt   = 1'b1;
          end
          if (in_last) begin
            w_idx_nxt   = 3'd0;
            w_state_nxt = (w_cnt_nxt < CNT_W'(MIN_LEN)) ? S_PAD : S_FCS;
          end
        end
      end
      S_PAD: begin
        if (w_adv) begin
          w_data_nxt  = 8'h00;
          w_valid_nxt = 1'b1;
          w_last_nxt  = 1'b0;
          w_crc_nxt   = crc_byte(r_crc, 8'h00);
          w_cnt_nxt   = w_cnt_inc;
          if (w_cnt_inc >= CNT_W'(MIN_LEN)) begin
            w_state_nxt = S_FCS;
          end
        end
      end
      S_FCS: begin
        // r_idx == 4 means every FCS byte has been loaded; wait for the last one to leave
        if (!r_idx[2]) begin
          if (w_adv) begin
            w_data_nxt  = w_fcs_byte;
            w_valid_nxt = 1'b1;
            w_last_nxt  = (r_idx == 3'd3);
            w_idx_nxt   = r_idx + 3'd1;
          end
        end else if (r_valid && out_ready) begin
          w_last_nxt  = 1'b0;
          w_done_nxt  = 1'b1;
          w_len_nxt   = r_cnt + CNT_W'(4);
          w_err_nxt   = r_ovf;
          w_cnt_nxt   = '0;
          w_ovf_nxt   = 1'b0;
          w_crc_nxt   = CRC_INIT;
          w_idx_nxt   = 3'd0;
          w_state_nxt = S_IDLE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_eth_tx_framer.sv
// Testbench for eth_tx_framer. A frame-level reference model feeds a scoreboard, and a monitor
// checks the output byte stream, stall stability, the inter-frame gap and frame_done/len/err.
module tb_eth_tx_framer;

  localparam int MIN_LEN = 60;
  localparam int MAX_LEN = 1514;

  typedef struct packed {
    logic [10:0] len;
    logic        err;
  } fres_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [7:0]  in_data = 8'h00;
  logic        in_valid = 1'b0;
  logic        in_last = 1'b0;
  logic        in_ready;
  logic [7:0]  out_data;
  logic        out_valid;
  logic        out_last;
  logic        out_ready = 1'b1;
  logic        frame_done;
  logic [10:0] frame_len;
  logic        frame_err;

  logic [7:0]  k_in_data = 8'h00;
  logic        k_in_valid = 1'b0;
  logic        k_in_last = 1'b0;
  logic        k_in_ready;
  logic [7:0]  k_out_data;
  logic        k_out_valid;
  logic        k_out_last;
  logic        k_out_ready = 1'b1;
  logic        k_done;
  logic [10:0] k_len;
  logic        k_err;

  eth_tx_framer #(.MIN_LEN(MIN_LEN), .MAX_LEN(MAX_LEN)) u_dut (
    .clk(clk), .rst(rst),
    .in_data(in_data), .in_valid(in_valid), .in_last(in_last), .in_ready(in_ready),
    .out_data(out_data), .out_valid(out_valid), .out_last(out_last), .out_ready(out_ready),
    .frame_done(frame_done), .frame_len(frame_len), .frame_err(frame_err)
  );

  eth_tx_framer #(.MIN_LEN(9), .MAX_LEN(MAX_LEN)) u_dut9 (
    .clk(clk), .rst(rst),
    .in_data(k_in_data), .in_valid(k_in_valid), .in_last(k_in_last), .in_ready(k_in_ready),
    .out_data(k_out_data), .out_valid(k_out_valid), .out_last(k_out_last), .out_ready(k_out_ready),
    .frame_done(k_done), .frame_len(k_len), .frame_err(k_err)
  );

  always #5 clk = ~clk;

  int          checks = 0;
  int          errors = 0;
  bit          rand_rdy = 1'b0;
  logic [31:0] crc_tbl [256];
  logic [8:0]  exp_q [$];
  fres_t       fres_q [$];
  bit          stall_prev = 1'b0;
  bit          gap = 1'b0;
  bit          done_due = 1'b0;
  logic [7:0]  held_d = 8'h00;
  logic        held_l = 1'b0;
  logic [31:0] run_crc = 32'hFFFFFFFF;
  logic [8:0]  k_q [$];
  bit          k_seen = 1'b0;
  logic [10:0] k_len_s = '0;
  logic        k_err_s = 1'b0;

  initial begin
    for (int i = 0; i < 256; i++) begin
      logic [31:0] c;
      c = 32'(i);
      for (int k = 0; k < 8; k++) c = c[0] ? ((c >> 1) ^ 32'hEDB88320) : (c >> 1);
      crc_tbl[i] = c;
    end
  end

  function automatic logic [31:0] crc_upd(input logic [31:0] c, input logic [7:0] d);
    return (c >> 8) ^ crc_tbl[c[7:0] ^ d];
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, required %0h", name, act, exp);
    end
  endtask

  // Reference model: truncate, pad, append complemented CRC LSB first
  task automatic model_push(input logic [7:0] f[$]);
    logic [7:0]  body [$];
    logic [31:0] c;
    fres_t       r;
    c = 32'hFFFFFFFF;
    for (int i = 0; i < f.size() && i < MAX_LEN; i++) body.push_back(f[i]);
    while (body.size() < MIN_LEN) body.push_back(8'h00);
    foreach (body[i]) begin
      c = crc_upd(c, body[i]);
      exp_q.push_back({1'b0, body[i]});
    end
    c = ~c;
    for (int b = 0; b < 4; b++) exp_q.push_back({(b == 3), c[8*b +: 8]});
    r.len = 11'(body.size() + 4);
    r.err = (f.size() > MAX_LEN);
    fres_q.push_back(r);
  endtask

  always @(posedge clk) begin
    #1;
    out_ready = rand_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
  end

  // Monitor: scoreboard pops on every output handshake
  always @(negedge clk) begin
    if (!rst) begin
      logic [8:0] e;
      fres_t      r;
      if (stall_prev) begin
        checks++;
        if (!out_valid || out_data !== held_d || out_last !== held_l) begin
          errors++;
          $display("FAIL stall_hold: got v=%0b d=%02h l=%0b, required v=1 d=%02h l=%0b",
                   out_valid, out_data, out_last, held_d, held_l);
        end
      end
      stall_prev = out_valid && !out_ready;
      held_d = out_data;
      held_l = out_last;
      if (gap) begin
        checks++;
        if (in_ready !== 1'b0) begin
          errors++;
          $display("FAIL gap_in_ready: got %0b, required 0", in_ready);
        end
      end
      checks++;
      if (frame_done !== done_due) begin
        errors++;
        $display("FAIL frame_done_timing: got %0b, required %0b", frame_done, done_due);
      end
      if (frame_done) begin
        if (fres_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL frame_unexpected: got len=%0d, required no frame", frame_len);
        end else begin
          r = fres_q.pop_front();
          chk("frame_len", 32'(frame_len), 32'(r.len));
          chk("frame_err", 32'(frame_err), 32'(r.err));
        end
      end
      done_due = out_valid && out_ready && out_last;
      if (out_valid && out_ready) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL byte_unexpected: got %02h, required none", out_data);
        end else begin
          e = exp_q.pop_front();
          if ({out_last, out_data} !== e) begin
            errors++;
            $display("FAIL out_byte: got l=%0b d=%02h, required l=%0b d=%02h",
                     out_last, out_data, e[8], e[7:0]);
          end
        end
        run_crc = crc_upd(run_crc, out_data);
        if (out_last) begin
          chk("crc_residue", run_crc, 32'hDEBB20E3);
          run_crc = 32'hFFFFFFFF;
          gap = 1'b0;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (!rst) begin
      if (k_out_valid && k_out_ready) k_q.push_back({k_out_last, k_out_data});
      if (k_done) begin
        k_seen = 1'b1;
        k_len_s = k_len;
        k_err_s = k_err;
      end
    end
  end

  task automatic send_byte(input logic [7:0] d, input logic l, output int waited);
    bit ok;
    waited = 0;
    ok = 1'b1;
    in_data = d;
    in_valid = 1'b1;
    in_last = l;
    forever begin
      @(negedge clk);
      if (in_ready) break;
      waited++;
      if (waited > 5000) begin
        checks++; errors++;
        $display("FAIL in_ready_timeout: got 0 for %0d cycles, required 1", waited);
        ok = 1'b0;
        break;
      end
      @(posedge clk);
      #1;
    end
    @(posedge clk);
    #1;
    if (l && ok) gap = 1'b1;
  endtask

  task automatic send_frame(input logic [7:0] f[$], input bit hold);
    int w;
    model_push(f);
    foreach (f[i]) begin
      send_byte(f[i], (i == f.size() - 1), w);
      if (i >= MAX_LEN && !rand_rdy) chk("drop_in_ready_wait", 32'(w), 32'd0);
    end
    if (!hold) begin
      in_valid = 1'b0;
      in_last = 1'b0;
    end
  endtask

  task automatic rand_frame(input int n, output logic [7:0] f[$]);
    f.delete();
    for (int i = 0; i < n; i++) f.push_back(8'($urandom));
  endtask

  task automatic wait_drain();
    int t;
    t = 0;
    while ((exp_q.size() != 0 || fres_q.size() != 0) && t < 20000) begin
      @(posedge clk);
      t++;
    end
    chk("drain_timeout", 32'(t >= 20000), 32'd0);
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_in_ready"}, 32'(in_ready), 32'd0);
    chk({tag, "_out_valid"}, 32'(out_valid), 32'd0);
    chk({tag, "_out_last"}, 32'(out_last), 32'd0);
    chk({tag, "_out_data"}, 32'(out_data), 32'd0);
    chk({tag, "_frame_done"}, 32'(frame_done), 32'd0);
    chk({tag, "_frame_len"}, 32'(frame_len), 32'd0);
    chk({tag, "_frame_err"}, 32'(frame_err), 32'd0);
  endtask

  initial begin
    logic [7:0] f [$];
    logic [7:0] g [$];
    logic [7:0] kat [4];
    int         w;
    int         t;
    kat = '{8'h26, 8'h39, 8'hF4, 8'hCB};

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk_reset_outputs("rst");
    rst = 1'b0;
    #1;
    chk("in_ready_after_rst", 32'(in_ready), 32'd1);
    @(posedge clk);
    #1;

    // "123456789" through the MIN_LEN=9 instance
    for (int i = 0; i < 9; i++) begin
      k_in_data = 8'h31 + 8'(i);
      k_in_valid = 1'b1;
      k_in_last = (i == 8);
      @(negedge clk);
      chk("kat_in_ready", 32'(k_in_ready), 32'd1);
      @(posedge clk);
      #1;
    end
    k_in_valid = 1'b0;
    k_in_last = 1'b0;
    t = 0;
    while (!k_seen && t < 100) begin
      @(posedge clk);
      t++;
    end
    #1;
    chk("kat_done_seen", 32'(k_seen), 32'd1);
    chk("kat_count", 32'(k_q.size()), 32'd13);
    if (k_q.size() == 13) begin
      for (int i = 0; i < 9; i++) chk("kat_payload", 32'(k_q[i]), 32'(9'h031 + 9'(i)));
      for (int i = 0; i < 4; i++) chk("kat_fcs", 32'(k_q[9+i]), 32'({(i == 3), kat[i]}));
    end
    chk("kat_len", 32'(k_len_s), 32'd13);
    chk("kat_err", 32'(k_err_s), 32'd0);

    // Minimal header-only frame, padded to 60 bytes
    f = '{8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF,
          8'h02, 8'h00, 8'h00, 8'h00, 8'h00, 8'h01, 8'h08, 8'h00};
    send_frame(f, 1'b0);
    wait_drain();

    // Exactly MAX_LEN, then the same bytes plus six more that are dropped
    rand_frame(MAX_LEN, f);
    send_frame(f, 1'b0);
    wait_drain();
    g = f;
    for (int i = 0; i < 6; i++) g.push_back(8'($urandom));
    send_frame(g, 1'b0);
    wait_drain();

    // Same 60-byte frame, first with out_ready high, then with random stalls
    rand_frame(MIN_LEN, f);
    send_frame(f, 1'b0);
    wait_drain();
    rand_rdy = 1'b1;
    send_frame(f, 1'b0);
    wait_drain();
    rand_rdy = 1'b0;

    // Back-to-back frames with in_valid held high
    rand_frame(20, f);
    rand_frame(70, g);
    send_frame(f, 1'b1);
    send_frame(g, 1'b0);
    wait_drain();

    // Reset partway through the payload
    rand_frame(40, f);
    model_push(f);
    for (int i = 0; i < 20; i++) send_byte(f[i], 1'b0, w);
    @(negedge clk);
    rst = 1'b1;
    in_valid = 1'b0;
    #1;
    chk_reset_outputs("midrst");
    exp_q.delete();
    fres_q.delete();
    stall_prev = 1'b0;
    gap = 1'b0;
    done_due = 1'b0;
    run_crc = 32'hFFFFFFFF;
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    rand_frame(50, f);
    send_frame(f, 1'b0);
    wait_drain();

    // Random lengths around the padding boundary and random back-pressure
    rand_rdy = 1'b1;
    for (int k = 0; k < 10; k++) begin
      int n;
      n = (k < 3) ? (MIN_LEN - 1 + k) : $urandom_range(1, 130);
      rand_frame(n, f);
      send_frame(f, (k < 9) ? 1'($urandom_range(0, 1)) : 1'b0);
    end
    wait_drain();
    rand_frame(MAX_LEN + 1, f);
    send_frame(f, 1'b0);
    wait_drain();
    rand_rdy = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
